// File: rtl/upower_multicycle_ctrl.sv
// Multi-cycle control FSM for the uPOWER load/store + R/I-form datapath.
// Define UPC_RETIRE_CNT_EN to add the `retired` counter port (width CNT_W).
module upower_multicycle_ctrl
`ifdef UPC_RETIRE_CNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] instr_q,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic        RegDst,
  output logic        XO,
  output logic [3:0]  ALU_OP,
  output logic        busy,
  output logic        done,
`ifdef UPC_RETIRE_CNT_EN
  output logic        illegal,
  output logic [CNT_W-1:0] retired
`else
  output logic        illegal
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR} state_t;
  typedef enum logic [1:0] {C_ILL, C_ALU, C_LD, C_STD} cls_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t     state;
  cls_t       cls;
  cls_t       dec_cls;
  logic [3:0] dec_op;
  logic       dec_asrc, dec_rdst, dec_xo, dec_m2r;
  logic       finishing;

  // Classify the latched word; anything not matched stays C_ILL.
  always_comb begin
    dec_cls  = C_ILL;
    dec_op   = 4'b0000;
    dec_asrc = 1'b0;
    dec_rdst = 1'b0;
    dec_xo   = 1'b0;
    dec_m2r  = 1'b0;
    case (instr_q[31:26])
      6'd58: if (instr_q[1:0] == 2'b00) begin
        dec_cls = C_LD;  dec_op = ALU_ADD; dec_asrc = 1'b1; dec_rdst = 1'b1; dec_m2r = 1'b1;
      end
      6'd62: if (instr_q[1:0] == 2'b00) begin
        dec_cls = C_STD; dec_op = ALU_ADD; dec_asrc = 1'b1; dec_rdst = 1'b1; dec_xo = 1'b1;
      end
      6'd14: begin
        dec_cls = C_ALU; dec_op = ALU_ADD; dec_asrc = 1'b1; dec_rdst = 1'b1; dec_xo = 1'b1;
      end
      6'd28: begin
        dec_cls = C_ALU; dec_op = ALU_AND; dec_asrc = 1'b1;
      end
      6'd24: begin
        dec_cls = C_ALU; dec_op = ALU_OR;  dec_asrc = 1'b1;
      end
      6'd31: begin
        case (instr_q[10:1])
          10'd266: begin dec_cls = C_ALU; dec_op = ALU_ADD; dec_rdst = 1'b1; dec_xo = 1'b1; end
          10'd40:  begin dec_cls = C_ALU; dec_op = ALU_SUB; dec_rdst = 1'b1; dec_xo = 1'b1; end
          10'd28:  begin dec_cls = C_ALU; dec_op = ALU_AND; dec_xo = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Last cycle of an instruction: the next state is IDLE.
  assign finishing = (state == S_WB) || (state == S_ERR) ||
                     ((state == S_MEM) && (cls != C_LD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cls         <= C_ILL;
      instr_q     <= 32'd0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      RegWrite    <= 1'b0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      MemtoReg    <= 1'b0;
      ALUSrc      <= 1'b0;
      RegDst      <= 1'b0;
      XO          <= 1'b0;
      ALU_OP      <= 4'b0000;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: if (instr_valid) begin
          instr_q     <= instr;
          instr_ready <= 1'b0;
          busy        <= 1'b1;
          state       <= S_DECODE;
        end
        S_DECODE: if (dec_cls == C_ILL) begin
          illegal <= 1'b1;
          state   <= S_ERR;
        end else begin
          cls      <= dec_cls;
          ALU_OP   <= dec_op;
          ALUSrc   <= dec_asrc;
          RegDst   <= dec_rdst;
          XO       <= dec_xo;
          MemtoReg <= dec_m2r;
          state    <= S_EXEC;
        end
        S_EXEC: if (cls == C_ALU) begin
          RegWrite <= 1'b1;
          done     <= 1'b1;
          state    <= S_WB;
        end else begin
          MemRead  <= (cls == C_LD);
          MemWrite <= (cls == C_STD);
          done     <= (cls == C_STD);
          state    <= S_MEM;
        end
        S_MEM: begin
          MemWrite <= 1'b0;
          if (cls == C_LD) begin
            RegWrite <= 1'b1;
            done     <= 1'b1;
            state    <= S_WB;
          end
        end
        default: ;
      endcase
      // Returning to IDLE clears every control and re-opens the handshake.
      if (finishing) begin
        state       <= S_IDLE;
        cls         <= C_ILL;
        instr_ready <= 1'b1;
        busy        <= 1'b0;
        RegWrite    <= 1'b0;
        MemRead     <= 1'b0;
        MemWrite    <= 1'b0;
        MemtoReg    <= 1'b0;
        ALUSrc      <= 1'b0;
        RegDst      <= 1'b0;
        XO          <= 1'b0;
        ALU_OP      <= 4'b0000;
      end
    end
  end

`ifdef UPC_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       retired <= '0;
    else if (done) retired <= retired + CNT_W'(1);
  end
`endif

endmodule
